// File: rtl/rob_core.sv
// rob_core: 2**ENTRY_W-entry reorder buffer with in-order retire into the alias table.
// A mispredicted head flushes every entry and pulses rollback one cycle after its commit.
module rob_core #(
    parameter int ENTRY_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               alloc_valid,
    input  logic [4:0]         alloc_rd,
    output logic               alloc_ready,
    output logic [ENTRY_W-1:0] alloc_index,
    input  logic               wb_valid,
    input  logic [ENTRY_W-1:0] wb_index,
    input  logic [31:0]        wb_data,
    input  logic               wb_mispredict,
    input  logic [31:0]        wb_target,
    input  logic [ENTRY_W-1:0] q1_index,
    input  logic [ENTRY_W-1:0] q2_index,
    output logic               q1_ready,
    output logic               q2_ready,
    output logic [31:0]        q1_data,
    output logic [31:0]        q2_data,
    output logic               commit_we,
    output logic [4:0]         commit_addr,
    output logic [31:0]        commit_data,
    output logic [ENTRY_W-1:0] commit_index,
    output logic               rollback,
    output logic [31:0]        redirect_pc,
    output logic               empty,
    output logic               full
);
    localparam int DEPTH = 2 ** ENTRY_W;

    logic [DEPTH-1:0]   r_busy, r_done, r_mispred;
    logic [4:0]         r_rd     [DEPTH];
    logic [31:0]        r_data   [DEPTH];
    logic [31:0]        r_target [DEPTH];
    logic [ENTRY_W-1:0] r_head, r_tail;
    logic [ENTRY_W:0]   r_count;
    logic               r_rollback;
    logic [31:0]        r_redirect_pc;
    logic               w_alloc, w_wb, w_fire, w_flush;

    // count never exceeds DEPTH, so its MSB alone marks full
    assign full         = r_count[ENTRY_W];
    assign empty        = r_count == '0;
    assign alloc_ready  = !full && !r_rollback;
    assign alloc_index  = r_tail;
    assign w_alloc      = alloc_valid && alloc_ready;
    assign w_wb         = wb_valid && r_busy[wb_index];
    assign w_fire       = r_busy[r_head] && r_done[r_head];
    assign w_flush      = w_fire && r_mispred[r_head];
    assign commit_we    = w_fire && r_rd[r_head] != 5'd0;
    assign commit_addr  = r_rd[r_head];
    assign commit_data  = r_data[r_head];
    assign commit_index = r_head;
    assign rollback     = r_rollback;
    assign redirect_pc  = r_redirect_pc;
    assign q1_ready     = r_busy[q1_index] && r_done[q1_index];
    assign q2_ready     = r_busy[q2_index] && r_done[q2_index];
    assign q1_data      = r_data[q1_index];
    assign q2_data      = r_data[q2_index];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy        <= '0;
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
            r_rollback    <= 1'b0;
            r_redirect_pc <= '0;
        end else begin
            r_rollback <= w_flush;
            if (w_flush) begin
                r_redirect_pc <= r_target[r_head];
                r_busy        <= '0;
                r_head        <= '0;
                r_tail        <= '0;
                r_count       <= '0;
            end else begin
                if (w_alloc) begin
                    r_busy[r_tail] <= 1'b1;
                    r_tail         <= r_tail + 1'b1;
                end
                if (w_fire) begin
                    r_busy[r_head] <= 1'b0;
                    r_head         <= r_head + 1'b1;
                end
                r_count <= r_count + (ENTRY_W+1)'(w_alloc) - (ENTRY_W+1)'(w_fire);
            end
        end
    end

    // payload needs no reset: busy gates every use of it
    always_ff @(posedge clk) begin
        if (w_alloc) begin
            r_done[r_tail]    <= 1'b0;
            r_mispred[r_tail] <= 1'b0;
            r_rd[r_tail]      <= alloc_rd;
        end
        if (w_wb) begin
            r_done[wb_index]    <= 1'b1;
            r_data[wb_index]    <= wb_data;
            r_mispred[wb_index] <= wb_mispredict;
            r_target[wb_index]  <= wb_target;
        end
    end
endmodule
